binary_to_bcd_seq: RTL

//  Parametrised multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_adjust.sv | 13 +
 rtl/binary_to_bcd_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state type, the add-3 digit correction and the digit-count sizing check.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_e;

  // Double-dabble correction: a digit of 5 or more would overflow past 9 when doubled.
  function automatic logic [3:0] digit_adjust(input logic [3:0] x);
    return (x >= 4'd5) ? x + 4'd3 : x;
  endfunction

  // Number of decimal digits needed to print the largest bin_w-bit unsigned value.
  function automatic int unsigned digits_needed(input int unsigned bin_w);
    longint unsigned max_val;
    int unsigned     n;
    max_val = (64'd1 << bin_w) - 64'd1;
    n = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit's add-3 correction stage, applied before each shift of the digit register.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = digit_adjust(i_digit);
  end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one bit per cycle, with valid/ready
// on both sides. Results are held in output registers until the consumer takes them.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndig
);

  localparam int unsigned CntW  = $clog2(BIN_W + 1);
  localparam int unsigned NdigW = $clog2(DIGITS + 1);
  localparam int unsigned BcdW  = 4 * DIGITS;

  if (BIN_W < 1) begin : g_bin_w_check
    $error("binary_to_bcd_seq: BIN_W must be at least 1");
  end

  if (DIGITS < digits_needed(BIN_W)) begin : g_digits_check
    $error("binary_to_bcd_seq: DIGITS too small to represent 2**BIN_W-1");
  end

  bcd_state_e          r_state;
  bcd_state_e          w_state_next;
  logic [CntW-1:0]     r_cnt;
  logic [BIN_W-1:0]    r_bin_sr;
  logic [BcdW-1:0]     r_bcd;
  logic [BcdW-1:0]     w_adj;
  logic [NdigW-1:0]    w_ndig;
  logic                r_out_valid;
  logic [BcdW-1:0]     r_out_bcd;
  logic [NdigW-1:0]    r_out_ndig;
  logic                w_unused_adj_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The top digit never exceeds 4 before correction when DIGITS is sized correctly,
  // so the bit shifted out of the register is always zero.
  assign w_unused_adj_msb = w_adj[BcdW-1];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)                  w_state_next = StShift;
      StShift: if (r_cnt == CntW'(1))         w_state_next = StDone;
      StDone:  if (r_out_valid && out_ready)  w_state_next = StIdle;
      default:                                w_state_next = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (r_state == StIdle);
  end

  // Significant digits: position of highest non-zero digit plus one, minimum one.
  always_comb begin
    w_ndig = NdigW'(1);
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_ndig = NdigW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bin_sr    <= '0;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_ndig  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_bin_sr <= in_data;
            r_bcd    <= '0;
            r_cnt    <= CntW'(BIN_W);
          end
        end
        StShift: begin
          r_bcd    <= {w_adj[BcdW-2:0], r_bin_sr[BIN_W-1]};
          r_bin_sr <= r_bin_sr << 1;
          r_cnt    <= r_cnt - CntW'(1);
        end
        StDone: begin
          // First DONE cycle latches the finished value; it then holds until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_bcd   <= r_bcd;
            r_out_ndig  <= w_ndig;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign out_ndig  = r_out_ndig;

endmodule
